// File: rtl/regfile_access_arbiter_if.sv
// rtl/regfile_access_arbiter_if.sv - requester, clear-control and register-file port bundle for regfile_access_arbiter
interface regfile_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      clr_start;
  logic                      busy;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [DATA_W-1:0]         rf_wdata;
  logic [ADDR_W-1:0]         rf_raddr;
  logic [DATA_W-1:0]         rf_rdata;

  modport master (
    output req, req_we, req_addr, req_wdata, clr_start, rf_rdata,
    input  gnt, rsp_valid, rsp_data, busy, rf_we, rf_waddr, rf_wdata, rf_raddr
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, clr_start, rf_rdata,
    output gnt, rsp_valid, rsp_data, busy, rf_we, rf_waddr, rf_wdata, rf_raddr
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// rtl/regfile_access_arbiter.sv - round-robin arbiter sharing one register file, with zero-fill clear sequencer
// Define RFARB_FIXED_PRIORITY_EN for a fixed-priority (lowest index wins) arbiter instead of round-robin.
module regfile_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4
) (
  input logic                     clk,
  input logic                     reset,
  regfile_access_arbiter_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [NUM_REQ-1:0]  gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

`ifdef RFARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (state == RUN && !bus.clr_start) begin
      // Descending scan so the lowest requesting index is the last to overwrite.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (bus.req[PTR_W'(i)]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'(i);
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end
`else
  logic [PTR_W-1:0] rr_ptr;

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (state == RUN && !bus.clr_start) begin
      for (int o = 1; o <= NUM_REQ; o++) begin
        idx = PTR_W'((int'(rr_ptr) + o) % NUM_REQ);
        if (!gnt_any && bus.req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = idx;
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end
`endif

  assign sel_we    = bus.req_we[gnt_idx];
  assign sel_addr  = bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    bus.gnt      = gnt;
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    bus.rf_raddr = '0;
    if (state == CLEAR) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = clr_cnt;
    end else if (gnt_any) begin
      if (sel_we) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = sel_addr;
        bus.rf_wdata = sel_wdata;
      end else begin
        bus.rf_raddr = sel_addr;
      end
    end
  end

  assign bus.busy      = (state == CLEAR);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifndef RFARB_FIXED_PRIORITY_EN
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
`endif
    end else begin
      rsp_valid_q <= gnt & ~bus.req_we;
      if (gnt_any && !sel_we) rsp_data_q <= bus.rf_rdata;
`ifndef RFARB_FIXED_PRIORITY_EN
      if (gnt_any) rr_ptr <= gnt_idx;
`endif
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= RUN;
        end
        RUN: begin
          if (bus.clr_start) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb/tb_regfile_access_arbiter.sv - scoreboard bench for regfile_access_arbiter (directed vectors)
module tb_regfile_access_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem[16];

  regfile_access_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_access_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clk) if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
  assign bus.rf_rdata = mem[bus.rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid !== '0) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1 << e.idx));
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [3:0] a, input logic [15:0] d);
    bus.req[k]              = 1'b1;
    bus.req_we[k]           = we;
    bus.req_addr[k*4 +: 4]  = a;
    bus.req_wdata[k*16 +: 16] = d;
  endtask

  task automatic clr_req(input int k);
    bus.req[k] = 1'b0;
  endtask

  task automatic wait_gnt(input int k, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.gnt[k]) found = 1'b1;
    end
    chk(name, 32'(found), 32'h1);
  endtask

  task automatic do_read(input int k, input logic [3:0] a, input logic [15:0] exp_d, input string name);
    exp_t e;
    set_req(k, 1'b0, a, 16'h0);
    e.idx  = k;
    e.data = exp_d;
    sb_q.push_back(e);
    wait_gnt(k, name);
    cyc();
    clr_req(k);
  endtask

  // Entered between a posedge and the following negedge; cnt is 0 at that negedge.
  task automatic check_clear(input string name);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk(name, {6'h0, bus.busy, bus.rf_we, bus.gnt, bus.rf_waddr, bus.rf_wdata},
                {6'h0, 1'b1, 1'b1, 4'h0, 4'(c), 16'h0});
    end
    @(negedge clk);
    chk({name, "_done"}, 32'(bus.busy), 32'h0);
  endtask

  logic [3:0] t4_exp[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    bus.req = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.clr_start = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'h1);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    cyc();
    reset = 1'b0;
    check_clear("init_clear");

    // First read after clear: requester 0 wins immediately, data is zero.
    cyc();
    begin
      exp_t e;
      set_req(0, 1'b0, 4'd3, 16'h0);
      e.idx = 0; e.data = 16'h0000; sb_q.push_back(e);
      @(negedge clk);
      chk("t2_gnt", 32'(bus.gnt), 32'h1);
      cyc();
      clr_req(0);

      // Write then read-after-write from another requester on the next cycle.
      set_req(1, 1'b1, 4'd5, 16'hBEEF);
      @(negedge clk);
      chk("t3_wr_gnt", 32'(bus.gnt), 32'h2);
      chk("t3_wr_port", {bus.rf_we, 7'h0, bus.rf_waddr, bus.rf_wdata}, {1'b1, 7'h0, 4'd5, 16'hBEEF});
      cyc();
      clr_req(1);
      set_req(2, 1'b0, 4'd5, 16'h0);
      e.idx = 2; e.data = 16'hBEEF; sb_q.push_back(e);
      @(negedge clk);
      chk("t3_rd_gnt", 32'(bus.gnt), 32'h4);
      cyc();
      clr_req(2);
    end

    // All four hold write requests; last grant went to requester 2.
`ifdef RFARB_FIXED_PRIORITY_EN
    t4_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    t4_exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    for (int k = 0; k < 4; k++) set_req(k, 1'b1, 4'(8 + k), 16'hA000 + 16'(k));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_gnt_seq", 32'(bus.gnt), 32'(t4_exp[i]));
      cyc();
    end
    for (int k = 0; k < 4; k++) clr_req(k);
    do_read(0, 4'd8, 16'hA000, "t4_readback_gnt");

    // Clear wins over a simultaneous write request, which stays pending.
    bus.clr_start = 1'b1;
    set_req(3, 1'b1, 4'd2, 16'h1234);
    @(negedge clk);
    chk("t5_gnt_suppressed", 32'(bus.gnt), 32'h0);
    chk("t5_busy_before", 32'(bus.busy), 32'h0);
    cyc();
    bus.clr_start = 1'b0;
    check_clear("t5_clear");
    chk("t5_pending_gnt", 32'(bus.gnt), 32'h8);
    chk("t5_pending_wr", {bus.rf_we, 7'h0, bus.rf_waddr, bus.rf_wdata}, {1'b1, 7'h0, 4'd2, 16'h1234});
    cyc();
    clr_req(3);
    do_read(1, 4'd2, 16'h1234, "t5_read_a2_gnt");
    do_read(2, 4'd8, 16'h0000, "t5_read_a8_gnt");

    // Reset in the cycle of a read grant drops its response.
    set_req(0, 1'b0, 4'd2, 16'h0);
    wait_gnt(0, "t6_rd_gnt");
    reset = 1'b1;
    clr_req(0);
    @(negedge clk);
    chk("t6_rsp_dropped", 32'(bus.rsp_valid), 32'h0);
    chk("t6_busy", 32'(bus.busy), 32'h1);
    cyc();
    reset = 0;
    check_clear("t6_clear");

    // Reset at cycle 8 of a clear restarts the sequence from entry 0.
    cyc();
    bus.clr_start = 1'b1;
    @(negedge clk);
    cyc();
    bus.clr_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t7_partial", {bus.busy, 3'h0, bus.rf_waddr}, {1'b1, 3'h0, 4'(c)});
    end
    reset = 1'b1;
    #1;
    chk("t7_rst_busy", 32'(bus.busy), 32'h1);
    chk("t7_rst_waddr", 32'(bus.rf_waddr), 32'h0);
    cyc();
    cyc();
    reset = 1'b0;
    check_clear("t7_clear");

    repeat (3) cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
